// File: rtl/dcache_snoop_responder_if.sv
// dcache_snoop_responder_if: snoop, writeback and frame-lookup signals between the dcache snoop responder and its environment
//   slave  : responder side (takes ccwait/ccinv/ccsnoopaddr, dwait, lk_*; drives ccwrite, snp_busy, dWEN/daddr/dstore, lk_idx/lk_tag, upd_*)
//   master : environment side (controller, memory port, frame arrays)
interface dcache_snoop_responder_if #(parameter int TAG_W = 26, parameter int IDX_W = 3);
  logic ccwait;
  logic ccinv;
  logic [31:0] ccsnoopaddr;
  logic ccwrite;
  logic snp_busy;
  logic dwait;
  logic dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic lk_hit;
  logic lk_way;
  logic lk_dirty;
  logic [31:0] lk_word0;
  logic [31:0] lk_word1;
  logic upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic upd_way;
  logic upd_inv;
  modport slave (
    input ccwait, ccinv, ccsnoopaddr, dwait, lk_hit, lk_way, lk_dirty, lk_word0, lk_word1,
    output ccwrite, snp_busy, dWEN, daddr, dstore, lk_idx, lk_tag, upd_en, upd_idx, upd_way, upd_inv
  );
  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait, lk_hit, lk_way, lk_dirty, lk_word0, lk_word1,
    input ccwrite, snp_busy, dWEN, daddr, dstore, lk_idx, lk_tag, upd_en, upd_idx, upd_way, upd_inv
  );
endinterface

// File: rtl/dcache_snoop_responder.sv
// dcache_snoop_responder: target end of the bus snoop; looks up the snooped line, writes back dirty data, then invalidates or downgrades it
//   CLK  : system clock
//   nRST : asynchronous active-low reset
//   bus  : snoop / writeback / frame-lookup signals (slave modport)
module dcache_snoop_responder #(
  parameter int TAG_W = 26,
  parameter int IDX_W = 3
) (
  input logic CLK,
  input logic nRST,
  dcache_snoop_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB0, WB1, RESP} state_t;
  state_t r_state;
  logic [31:3] r_saddr;
  logic [31:0] r_w0, r_w1;
  logic r_hit, r_way, r_first;
  logic w_wb;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_saddr <= '0;
      r_w0 <= '0;
      r_w1 <= '0;
      r_hit <= 1'b0;
      r_way <= 1'b0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.ccwait) begin
          r_saddr <= bus.ccsnoopaddr[31:3];
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          r_hit <= bus.lk_hit;
          r_way <= bus.lk_way;
          r_w0 <= bus.lk_word0;
          r_w1 <= bus.lk_word1;
          r_state <= (bus.lk_hit & bus.lk_dirty) ? WB0 : RESP;
          r_first <= !(bus.lk_hit & bus.lk_dirty);
        end
        WB0: if (!bus.dwait) r_state <= WB1;
        WB1: if (!bus.dwait) begin
          r_state <= RESP;
          r_first <= 1'b1;
        end
        RESP: begin
          r_first <= 1'b0;
          if (!bus.ccwait) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_wb = (r_state == WB0) || (r_state == WB1);
  assign bus.snp_busy = r_state != IDLE;
  // r_hit still holds the previous snoop's result during LOOKUP, so it is masked there
  assign bus.ccwrite = r_hit & (w_wb || r_state == RESP);
  assign bus.dWEN = w_wb;
  assign bus.daddr = w_wb ? {r_saddr, r_state == WB1, 2'b00} : 32'h0;
  assign bus.dstore = (r_state == WB0) ? r_w0 : (r_state == WB1) ? r_w1 : 32'h0;
  assign bus.lk_idx = r_saddr[3 +: IDX_W];
  assign bus.lk_tag = r_saddr[31 -: TAG_W];
  // ccinv is taken live in the single strobe cycle
  assign bus.upd_en = r_first & r_hit;
  assign bus.upd_inv = r_first & r_hit & bus.ccinv;
  assign bus.upd_idx = r_saddr[3 +: IDX_W];
  assign bus.upd_way = r_way;
endmodule

// File: tb/tb_dcache_snoop_responder.sv
// tb_dcache_snoop_responder: directed self-checking bench for dcache_snoop_responder
module tb_dcache_snoop_responder;
  logic CLK = 1'b0;
  logic nRST;
  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int upd_cnt = 0;
  int b_wen, b_upd;
  dcache_snoop_responder_if #(.TAG_W(26), .IDX_W(3)) bus ();
  dcache_snoop_responder #(.TAG_W(26), .IDX_W(3)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (bus.dWEN) wen_cnt++;
    if (bus.upd_en) upd_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask
  task automatic mark;
    b_wen = wen_cnt;
    b_upd = upd_cnt;
  endtask
  initial begin
    nRST = 1'b0;
    bus.ccwait = 1'b0;
    bus.ccinv = 1'b0;
    bus.ccsnoopaddr = 32'h0;
    bus.dwait = 1'b0;
    bus.lk_hit = 1'b0;
    bus.lk_way = 1'b0;
    bus.lk_dirty = 1'b0;
    bus.lk_word0 = 32'h0;
    bus.lk_word1 = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ccwrite", bus.ccwrite, 0);
    chk("rst_busy", bus.snp_busy, 0);
    chk("rst_dwen", bus.dWEN, 0);
    chk("rst_daddr", bus.daddr, 0);
    chk("rst_dstore", bus.dstore, 0);
    chk("rst_upd_en", bus.upd_en, 0);
    chk("rst_upd_inv", bus.upd_inv, 0);
    chk("rst_lk_idx", bus.lk_idx, 0);
    chk("rst_lk_tag", bus.lk_tag, 0);
    nRST = 1'b1;
    step;
    // miss, ccwait held for 4 sampled cycles
    mark;
    bus.ccsnoopaddr = 32'h0000_1238;
    bus.ccwait = 1'b1;
    step;
    chk("miss_lk_idx", bus.lk_idx, 7);
    chk("miss_lk_tag", bus.lk_tag, 32'h48);
    chk("miss_busy_lookup", bus.snp_busy, 1);
    bus.ccsnoopaddr = 32'hFFFF_FFFF;
    step;
    chk("miss_ccwrite", bus.ccwrite, 0);
    step;
    step;
    bus.ccwait = 1'b0;
    chk("miss_addr_held", bus.lk_idx, 7);
    chk("miss_busy_resp", bus.snp_busy, 1);
    step;
    chk("miss_busy_idle", bus.snp_busy, 0);
    chk("miss_no_wen", wen_cnt - b_wen, 0);
    chk("miss_no_upd", upd_cnt - b_upd, 0);
    // clean hit, BusRd
    mark;
    bus.ccsnoopaddr = 32'h0000_0048;
    bus.lk_hit = 1'b1;
    bus.lk_way = 1'b1;
    bus.lk_dirty = 1'b0;
    bus.ccinv = 1'b0;
    bus.ccwait = 1'b1;
    step;
    chk("clean_ccwrite_lookup", bus.ccwrite, 0);
    step;
    chk("clean_ccwrite", bus.ccwrite, 1);
    chk("clean_upd_en", bus.upd_en, 1);
    chk("clean_upd_idx", bus.upd_idx, 1);
    chk("clean_upd_way", bus.upd_way, 1);
    chk("clean_upd_inv", bus.upd_inv, 0);
    step;
    chk("clean_upd_once", bus.upd_en, 0);
    bus.ccwait = 1'b0;
    step;
    chk("clean_idle_ccwrite", bus.ccwrite, 0);
    chk("clean_upd_cnt", upd_cnt - b_upd, 1);
    chk("clean_no_wen", wen_cnt - b_wen, 0);
    // dirty hit, BusRdX, two wait cycles per word
    mark;
    bus.ccsnoopaddr = 32'h0000_00F4;
    bus.lk_way = 1'b0;
    bus.lk_dirty = 1'b1;
    bus.lk_word0 = 32'hDEAD_BEEF;
    bus.lk_word1 = 32'hCAFE_F00D;
    bus.ccinv = 1'b1;
    bus.dwait = 1'b1;
    bus.ccwait = 1'b1;
    step;
    step;
    chk("dirty_wb0_wen", bus.dWEN, 1);
    chk("dirty_wb0_addr", bus.daddr, 32'hF0);
    chk("dirty_wb0_data", bus.dstore, 32'hDEAD_BEEF);
    chk("dirty_wb0_ccwrite", bus.ccwrite, 1);
    step;
    step;
    chk("dirty_wb0_hold", bus.daddr, 32'hF0);
    bus.dwait = 1'b0;
    step;
    chk("dirty_wb1_addr", bus.daddr, 32'hF4);
    chk("dirty_wb1_data", bus.dstore, 32'hCAFE_F00D);
    bus.dwait = 1'b1;
    step;
    step;
    bus.dwait = 1'b0;
    step;
    chk("dirty_upd_en", bus.upd_en, 1);
    chk("dirty_upd_inv", bus.upd_inv, 1);
    chk("dirty_upd_idx", bus.upd_idx, 6);
    chk("dirty_upd_way", bus.upd_way, 0);
    chk("dirty_resp_wen", bus.dWEN, 0);
    chk("dirty_resp_daddr", bus.daddr, 0);
    chk("dirty_wen_cycles", wen_cnt - b_wen, 6);
    bus.ccwait = 1'b0;
    step;
    chk("dirty_idle_busy", bus.snp_busy, 0);
    chk("dirty_upd_cnt", upd_cnt - b_upd, 1);
    // ccwait drops during WB0
    mark;
    bus.ccsnoopaddr = 32'h0000_100C;
    bus.lk_word0 = 32'h1111_1111;
    bus.lk_word1 = 32'h2222_2222;
    bus.ccinv = 1'b0;
    bus.dwait = 1'b1;
    bus.ccwait = 1'b1;
    step;
    step;
    bus.ccwait = 1'b0;
    step;
    chk("drop_wb0_addr", bus.daddr, 32'h1008);
    chk("drop_wb0_data", bus.dstore, 32'h1111_1111);
    bus.dwait = 1'b0;
    step;
    chk("drop_wb1_addr", bus.daddr, 32'h100C);
    chk("drop_wb1_data", bus.dstore, 32'h2222_2222);
    step;
    chk("drop_upd_en", bus.upd_en, 1);
    chk("drop_upd_inv", bus.upd_inv, 0);
    chk("drop_upd_idx", bus.upd_idx, 1);
    step;
    chk("drop_idle_busy", bus.snp_busy, 0);
    chk("drop_wen_cycles", wen_cnt - b_wen, 3);
    // reset during WB1
    bus.ccsnoopaddr = 32'h0000_00F4;
    bus.dwait = 1'b1;
    bus.ccwait = 1'b1;
    step;
    step;
    bus.dwait = 1'b0;
    step;
    bus.dwait = 1'b1;
    chk("rstwb_wb1_addr", bus.daddr, 32'hF4);
    nRST = 1'b0;
    #1;
    chk("rstwb_wen", bus.dWEN, 0);
    chk("rstwb_ccwrite", bus.ccwrite, 0);
    chk("rstwb_busy", bus.snp_busy, 0);
    chk("rstwb_daddr", bus.daddr, 0);
    mark;
    bus.ccwait = 1'b0;
    bus.dwait = 1'b0;
    step;
    nRST = 1'b1;
    step;
    step;
    chk("rstwb_no_upd", upd_cnt - b_upd, 0);
    chk("rstwb_idle", bus.snp_busy, 0);
    // back-to-back: A clean hit, B miss
    bus.ccsnoopaddr = 32'h0000_0088;
    bus.lk_hit = 1'b1;
    bus.lk_dirty = 1'b0;
    bus.ccinv = 1'b1;
    bus.ccwait = 1'b1;
    step;
    step;
    chk("b2b_a_ccwrite", bus.ccwrite, 1);
    chk("b2b_a_upd_inv", bus.upd_inv, 1);
    bus.ccwait = 1'b0;
    step;
    step;
    bus.ccsnoopaddr = 32'h0000_2000;
    bus.lk_hit = 1'b0;
    bus.ccwait = 1'b1;
    step;
    chk("b2b_b_lk_idx", bus.lk_idx, 0);
    chk("b2b_b_lk_tag", bus.lk_tag, 32'h80);
    chk("b2b_b_ccwrite_lookup", bus.ccwrite, 0);
    step;
    chk("b2b_b_ccwrite", bus.ccwrite, 0);
    chk("b2b_b_upd_en", bus.upd_en, 0);
    bus.ccwait = 1'b0;
    step;
    chk("b2b_idle", bus.snp_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
